ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_if.sv | 34 +++
 rtl/ram_arbiter.sv | 119 +++++++++++
 2 files changed

// File: rtl/ram_arbiter_if.sv
// Bus bundle between two requesters, the shared RAM and the arbiter.
// The arbiter uses the slave view; the environment (clients plus RAM) uses the master view.
interface ram_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          ack0;
  logic          ack1;
  logic [DW-1:0] rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_wren;
  logic          ram_rden;
  logic [DW-1:0] ram_rdata;
  logic          busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
    output ack0, ack1, rdata, ram_addr, ram_wdata, ram_wren, ram_rden, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
    input  ack0, ack1, rdata, ram_addr, ram_wdata, ram_wren, ram_rden, busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM.
// One transaction at a time: IDLE -> ACCESS (-> RDWAIT for reads) -> IDLE.
module ram_arbiter #(
  parameter int data_size    = 1024,
  parameter int address_size = 32,
  localparam int AW          = $clog2(data_size - 1)
) (
  input  logic         CLK,
  input  logic         RESET_N,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } state_e;

  state_e                  state_q;
  logic                    last_grant_q;
  logic                    gnt_q;
  logic                    we_q;
  logic [AW-1:0]           addr_q;
  logic [address_size-1:0] wdata_q;
  logic                    ram_wren_q;
  logic                    ram_rden_q;
  logic                    ack0_q;
  logic                    ack1_q;
  logic                    rd_ack_q;

  logic                    any_req_d;
  logic                    grant_d;
  logic                    sel_we_d;
  logic [AW-1:0]           sel_addr_d;
  logic [address_size-1:0] sel_wdata_d;

  // Under contention the port that did not win last time goes next.
  always_comb begin
    any_req_d = bus.req0 | bus.req1;
    grant_d   = 1'b0;
    if (bus.req0 && bus.req1) begin
      grant_d = ~last_grant_q;
    end else if (bus.req1) begin
      grant_d = 1'b1;
    end
    sel_we_d    = grant_d ? bus.we1    : bus.we0;
    sel_addr_d  = grant_d ? bus.addr1  : bus.addr0;
    sel_wdata_d = grant_d ? bus.wdata1 : bus.wdata0;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ram_wren_q   <= 1'b0;
      ram_rden_q   <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rd_ack_q     <= 1'b0;
    end else begin
      ram_wren_q <= 1'b0;
      ram_rden_q <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rd_ack_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req_d) begin
            gnt_q        <= grant_d;
            last_grant_q <= grant_d;
            we_q         <= sel_we_d;
            addr_q       <= sel_addr_d;
            wdata_q      <= sel_wdata_d;
            ram_wren_q   <= sel_we_d;
            ram_rden_q   <= ~sel_we_d;
            // A write completes in the ACCESS cycle itself.
            ack0_q       <= sel_we_d & ~grant_d;
            ack1_q       <= sel_we_d & grant_d;
            state_q      <= ACCESS;
          end
        end
        ACCESS: begin
          if (we_q) begin
            state_q <= IDLE;
          end else begin
            ack0_q   <= ~gnt_q;
            ack1_q   <= gnt_q;
            rd_ack_q <= 1'b1;
            state_q  <= RDWAIT;
          end
        end
        RDWAIT: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Acks and read data are masked by reset so an aborted transaction never completes.
  assign bus.ack0      = ack0_q & RESET_N;
  assign bus.ack1      = ack1_q & RESET_N;
  assign bus.rdata     = (rd_ack_q && RESET_N) ? bus.ram_rdata : '0;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.ram_wren  = ram_wren_q;
  assign bus.ram_rden  = ram_rden_q;
  assign bus.busy      = (state_q != IDLE);

  a_wren_rden_excl: assert property (@(posedge CLK) !(ram_wren_q && ram_rden_q));
  a_ack_onehot:     assert property (@(posedge CLK) !(ack0_q && ack1_q));

endmodule
